// File: rtl/rom_word_fetcher_pkg.sv
// Shared types and widths for the ROM word fetcher.
package fetch_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic {
    FETCH,
    DONE
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } fetch_word_t;

endpackage

// File: rtl/rom_word_fetcher_if.sv
// Word delivery handshake between the fetcher (master) and decode (slave).
interface rom_word_fetcher_if;
  import fetch_pkg::*;

  logic [WORD_W-1:0] word_data;
  logic [ADDR_W-1:0] word_addr;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, word_addr, word_valid, input word_ready);
  modport slave  (input word_data, word_addr, word_valid, output word_ready);
endinterface

// File: rtl/rom_word_fetcher_fifo.sv
// Two-entry synchronous FIFO of fetched words; flush overrides push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        full,
  output logic        empty
);

  fetch_word_t mem_q [DEPTH];
  fetch_word_t mem_d [DEPTH];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'(DEPTH));
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = !wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = !rd_ptr_q;
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rom_word_fetcher.sv
// Byte-wide ROM reader assembling little-endian 32-bit words into a 2-deep FIFO.
// Optional macro FETCH_STALL_CNT_EN adds the stall_cycles counter output.
module rom_word_fetcher
  import fetch_pkg::*;
#(
  parameter int ROM_SIZE   = 112,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [BYTE_W-1:0]   rom_byte,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  output logic                done,
  rom_word_fetcher_if.master  word_if
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  if (ROM_SIZE <= 0 || (ROM_SIZE % 4) != 0) begin : g_bad_rom_size
    $fatal(1, "rom_word_fetcher: ROM_SIZE must be a non-zero multiple of 4");
  end
  if (FIFO_DEPTH != 2) begin : g_bad_fifo_depth
    $fatal(1, "rom_word_fetcher: only FIFO_DEPTH=2 is supported");
  end

  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(ROM_SIZE);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;

  logic        fifo_full, fifo_empty;
  logic        at_end, pop, blocked, step, push;
  fetch_word_t push_word, head_word;
  logic        unused_redir_lsbs;

  assign unused_redir_lsbs = ^redirect_addr[1:0];

  assign at_end  = (ptr_q >= END_ADDR);
  assign pop     = !fifo_empty && word_if.word_ready;
  assign blocked = (idx_q == 2'd3) && fifo_full && !pop;
  assign step    = (state_q == FETCH) && en && !at_end && !blocked;
  assign push    = step && (idx_q == 2'd3);

  // Lane 3 comes straight from the ROM on the completing step.
  assign push_word.data = {rom_byte, asm_q};
  assign push_word.addr = ptr_q - 32'd3;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    if (redirect_valid) begin
      ptr_d   = {redirect_addr[ADDR_W-1:2], 2'b00};
      idx_d   = 2'd0;
      asm_d   = '0;
      state_d = FETCH;
    end else begin
      if (step) begin
        ptr_d = ptr_q + 32'd1;
        idx_d = idx_q + 2'd1;
        if (idx_q != 2'd3) asm_d[{idx_q, 3'b000} +: 8] = rom_byte;
      end
      if (ptr_d >= END_ADDR) state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ptr_q   <= '0;
      idx_q   <= 2'd0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push && !redirect_valid),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_word),
    .dout  (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A redirect past the end parks the address at ROM_SIZE until DONE is entered.
  assign rom_address        = at_end ? END_ADDR : ptr_q;
  assign done               = (state_q == DONE);
  assign word_if.word_data  = head_word.data;
  assign word_if.word_addr  = head_word.addr;
  assign word_if.word_valid = !fifo_empty;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (redirect_valid) stall_d = '0;
    else if ((state_q == FETCH) && en && blocked && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_rom_word_fetcher.sv
// Directed bench for rom_word_fetcher with a word-stream reference model.
module tb_rom_word_fetcher;

  localparam int ROM_SIZE = 112;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic [31:0] rom_address;
  logic [7:0]  rom_byte;
  logic        done;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  rom_word_fetcher_if wif();

  rom_word_fetcher #(.ROM_SIZE(ROM_SIZE), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .rom_address    (rom_address),
    .rom_byte       (rom_byte),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .done           (done),
    .word_if        (wif)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]  rom [ROM_SIZE];
  int          nchecks = 0;
  int          nerrors = 0;
  logic [31:0] exp_addr = '0;
  logic [63:0] dlog [$];
  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b0;
  logic        prev_redir = 1'b0;
  logic [63:0] prev_word = '0;

  assign rom_byte = (rom_address < ROM_SIZE) ? rom[rom_address[6:0]] : 8'h00;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] img_word(int i);
    case (i)
      0, 1:    return 32'h0000_0001;
      2:       return 32'h0000_0005;
      3:       return 32'h0000_010E;
      23:      return 32'h5A0B_9000;
      27:      return 32'h0000_0000;
      default: return {8'(i), 8'hC3, 8'(i * 7), 8'h5A};
    endcase
  endfunction

  function automatic logic [31:0] model_word(logic [31:0] addr);
    int a = int'(addr);
    if (a + 3 >= ROM_SIZE) return 32'hDEAD_BEEF;
    return {rom[a + 3], rom[a + 2], rom[a + 1], rom[a]};
  endfunction

  initial begin
    logic [31:0] w;
    for (int i = 0; i < ROM_SIZE / 4; i++) begin
      w = img_word(i);
      for (int k = 0; k < 4; k++) rom[4 * i + k] = w[8 * k +: 8];
    end
  end

  // Reference: words must leave in strict address order starting at the last restart point.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      check("rom_address_range", 64'(rom_address <= ROM_SIZE), 64'd1);
      if (prev_vld && !prev_rdy && !prev_redir) begin
        check("hold_valid", 64'(wif.word_valid), 64'd1);
        check("hold_word", {wif.word_addr, wif.word_data}, prev_word);
      end
      if (wif.word_valid && wif.word_ready && !redirect_valid) begin
        check("stream_addr", 64'(wif.word_addr), 64'(exp_addr));
        check("stream_data", 64'(wif.word_data), 64'(model_word(exp_addr)));
        dlog.push_back({wif.word_addr, wif.word_data});
        exp_addr = exp_addr + 32'd4;
      end
      if (redirect_valid) exp_addr = {redirect_addr[31:2], 2'b00};
      prev_vld   = wif.word_valid;
      prev_rdy   = wif.word_ready;
      prev_redir = redirect_valid;
      prev_word  = {wif.word_addr, wif.word_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic rdy);
    rst_n          = 1'b0;
    en             = 1'b0;
    redirect_valid = 1'b0;
    wif.word_ready = rdy;
    tick(2);
  endtask

  task automatic release_reset();
    exp_addr = '0;
    dlog.delete();
    en    = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drained(input string name);
    int cyc = 0;
    while (!(done && !wif.word_valid) && cyc < 400) begin
      tick(1);
      cyc++;
    end
    check(name, 64'(cyc < 400), 64'd1);
  endtask

  initial begin
    wif.word_ready = 1'b0;

    // Reset values and first-word latency.
    hold_reset(1'b1);
    check("rst_rom_address", 64'(rom_address), 64'd0);
    check("rst_word_valid", 64'(wif.word_valid), 64'd0);
    check("rst_word_data", 64'(wif.word_data), 64'd0);
    check("rst_word_addr", 64'(wif.word_addr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    release_reset();
    tick(3);
    check("first_valid_early", 64'(wif.word_valid), 64'd0);
    tick(1);
    check("first_valid", 64'(wif.word_valid), 64'd1);
    check("first_word", {wif.word_addr, wif.word_data}, {32'd0, 32'h0000_0001});
    tick(16);
    check("s1_count", 64'(dlog.size()), 64'd4);
    if (dlog.size() == 4) begin
      check("s1_w0", dlog[0], {32'd0,  32'h0000_0001});
      check("s1_w1", dlog[1], {32'd4,  32'h0000_0001});
      check("s1_w2", dlog[2], {32'd8,  32'h0000_0005});
      check("s1_w3", dlog[3], {32'd12, 32'h0000_010E});
    end

    // Backpressure from the start: FIFO fills, fetch parks on byte 11.
    hold_reset(1'b0);
    release_reset();
    tick(20);
    check("bp_rom_address", 64'(rom_address), 64'd11);
    check("bp_head", {wif.word_addr, wif.word_data}, {32'd0, 32'h0000_0001});
`ifdef FETCH_STALL_CNT_EN
    check("bp_stall_cycles", 64'(stall_cycles), 64'd9);
`endif
    wif.word_ready = 1'b1;
    tick(3);
    check("bp_count", 64'(dlog.size()), 64'd3);
    if (dlog.size() == 3) begin
      check("bp_a0", 64'(dlog[0][63:32]), 64'd0);
      check("bp_a1", 64'(dlog[1][63:32]), 64'd4);
      check("bp_a2", 64'(dlog[2][63:32]), 64'd8);
    end

    // Run to the end of the ROM.
    wait_drained("end_reached");
    check("end_done", 64'(done), 64'd1);
    check("end_rom_address", 64'(rom_address), 64'd112);
    check("end_count", 64'(dlog.size()), 64'd28);
    if (dlog.size() == 28) begin
      check("end_w92", dlog[23], {32'd92, 32'h5A0B_9000});
      check("end_w108", dlog[27], {32'd108, 32'h0000_0000});
    end
`ifdef FETCH_STALL_CNT_EN
    check("end_stall_cycles", 64'(stall_cycles), 64'd9);
`endif

    // Redirect out of DONE back to 0, with an enable gap mid-word.
    redirect_addr  = 32'd0;
    redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    check("rd0_done", 64'(done), 64'd0);
    check("rd0_valid", 64'(wif.word_valid), 64'd0);
`ifdef FETCH_STALL_CNT_EN
    check("rd0_stall_clear", 64'(stall_cycles), 64'd0);
`endif
    tick(2);
    en = 1'b0;
    tick(5);
    check("en_low_hold", 64'(rom_address), 64'd2);
    en = 1'b1;
    tick(2);
    check("rd0_valid_again", 64'(wif.word_valid), 64'd1);
    check("rd0_word", {wif.word_addr, wif.word_data}, {32'd0, 32'h0000_0001});

    // Redirect with FIFO full and a partial word, pop in the same cycle discarded.
    hold_reset(1'b0);
    release_reset();
    tick(10);
    check("rdm_rom_address", 64'(rom_address), 64'd10);
    check("rdm_valid_before", 64'(wif.word_valid), 64'd1);
    redirect_addr  = 32'h0000_005E;
    redirect_valid = 1'b1;
    wif.word_ready = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    dlog.delete();
    check("rdm_valid_after", 64'(wif.word_valid), 64'd0);
    check("rdm_rom_address_after", 64'(rom_address), 64'd92);
    wait_drained("rdm_drained");
    check("rdm_count", 64'(dlog.size()), 64'd5);
    if (dlog.size() == 5) check("rdm_first", dlog[0], {32'd92, 32'h5A0B_9000});

    // Asynchronous reset mid-word with the FIFO full.
    hold_reset(1'b0);
    release_reset();
    tick(9);
    check("ar_valid_before", 64'(wif.word_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rom_address", 64'(rom_address), 64'd0);
    check("ar_word_valid", 64'(wif.word_valid), 64'd0);
    check("ar_word_data", 64'(wif.word_data), 64'd0);
    check("ar_word_addr", 64'(wif.word_addr), 64'd0);
    check("ar_done", 64'(done), 64'd0);
`ifdef FETCH_STALL_CNT_EN
    check("ar_stall_cycles", 64'(stall_cycles), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/rom_word_fetcher.md
Name: rom_word_fetcher

Overview:
- Sits directly downstream of the byte-wide combinational program ROM.
- Drives the ROM byte address and assembles four consecutive bytes, little-endian, into 32-bit instruction words.
- Buffers assembled words in a 2-entry FIFO and presents them to the decode stage over a valid/ready handshake.
- Supports a redirect (jump) input from execute that flushes and restarts fetch.

Parameters:
ROM_SIZE, 112, ROM size in bytes; must be a non-zero multiple of 4 (elaboration-time check, fatal otherwise)
FIFO_DEPTH, 2, output buffer entries; only 2 is supported in this revision

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  fetch enable; low = no new ROM reads, FIFO still drains
rom_address  out  32  byte address to ROM = fetch pointer
rom_byte  in  8  ROM data, combinational from rom_address, same cycle
word_data  out  32  FIFO head word
word_addr  out  32  byte address of word_data's byte 0
word_valid  out  1  FIFO non-empty
word_ready  in  1  consumer accepts head when word_valid && word_ready
redirect_valid  in  1  flush and restart fetch
redirect_addr  in  32  new fetch address; low 2 bits ignored
done  out  1  pointer reached ROM_SIZE and no redirect pending

Behaviour:
- Reset (async, rst_n low): ptr=0, byte_idx=0, assembly register=0, FIFO empty, state=FETCH.
- Reset values of outputs: rom_address=0, word_valid=0, word_data=0, word_addr=0, done=0.
- States:
  - FETCH: reads the ROM.
  - DONE: ptr==ROM_SIZE with byte_idx==0; done=1, no reads.
- Fetch step, taken in FETCH when en=1 and not blocked:
  - rom_byte is written into assembly lane byte_idx (bits 8*byte_idx+7:8*byte_idx).
  - ptr+=1; byte_idx+=1 (mod 4).
- Push: on the step with byte_idx==3, the word {rom_byte, lane2, lane1, lane0} is written into the FIFO with word_addr = ptr-3.
  - First word is visible (word_valid=1) on the cycle after its 4th byte is read, i.e. 4 cycles after reset release with en=1.
  - Steady-state throughput: 1 word per 4 cycles.
- Blocking: the step is blocked only when byte_idx==3 AND FIFO full AND no pop this cycle. While blocked, ptr and byte_idx hold and rom_address is stable.
- Pop and push in the same cycle with the FIFO full are legal; the count stays at 2.
- Entering DONE: when ptr==ROM_SIZE and byte_idx==0, state goes to DONE. No ROM address >= ROM_SIZE is ever driven; rom_address holds ROM_SIZE. The FIFO still drains in DONE.
- en low mid-word: the partial word is held and fetch resumes at the same byte_idx when en returns high.
- Redirect (highest priority, any state):
  - FIFO flushed, including a pop in the same cycle, which is discarded.
  - Partial word discarded; byte_idx=0; ptr = {redirect_addr[31:2], 2'b00}; state=FETCH.
  - word_valid=0 on the next cycle.
- Redirect to an address >= ROM_SIZE: enters DONE on the following cycle.
- Handshake: word_data and word_addr are stable while word_valid && !word_ready. word_ready is ignored when word_valid=0.

Optional Feature:
FETCH_STALL_CNT_EN
- Defined: adds output stall_cycles (32 bit).
  - Counts cycles with state==FETCH && en && the fetch step blocked.
  - Reset to 0; also cleared on redirect; saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - constants BYTE_W=8, WORD_W=32, ADDR_W=32;
  - state enum {FETCH, DONE};
  - struct fetch_word_t {data[31:0], addr[31:0]}.
- Sub-module fetch_fifo: 2-entry synchronous FIFO of fetch_word_t with push, pop, flush, full, empty.
  - flush overrides push and pop.

Test Plan:
- Reset release, en=1, word_ready=1, standard ROM image:
  - words arrive at addr 0, 4, 8, 12 with data 0x00000001, 0x00000001, 0x00000005, 0x0000010E;
  - first word_valid 4 cycles after reset release.
- word_ready=0 from start:
  - FIFO fills with addr 0 and 4;
  - rom_address sticks at 11 (byte_idx==3, blocked) with ROM byte 11 not yet consumed;
  - raise word_ready: words 0, 4, 8 delivered in order, none lost or duplicated.
- Run to end with word_ready=1:
  - last word addr 108 = 0x00000000; addr 92 = 0x5A0B9000;
  - done=1 after it; rom_address never exceeds 112.
- Redirect mid-word and with FIFO full:
  - redirect_valid at byte_idx==2, redirect_addr=0x5E;
  - next cycle word_valid=0; next delivered word is addr 92 = 0x5A0B9000.
- Redirect in DONE to addr 0: done drops and word 0x00000001 at addr 0 is delivered again.
- rst_n asserted mid-word and with FIFO full: all outputs reach reset values immediately, without waiting for a clock edge.
  - with FETCH_STALL_CNT_EN defined: stall_cycles equals the number of blocked cycles in scenario 2.
